// File: rtl/seg7_scan_driver_if.sv
// Display-side bus for seg7_scan_driver.
// Carries the value/mask load strobe in and the multiplexed
// active-low anode/segment drive out.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output value, dp_mask, blank_mask, load,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  value, dp_mask, blank_mask, load,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed common-anode seven-segment driver.
// A refresh counter steps a digit index 0..3; values are double-buffered
// (pending -> display at the frame boundary) so a frame never tears.
// Optional macro LEADING_ZERO_BLANK_EN: auto-blank leading zero digits 3..1.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [15:0] value;
    } frame_t;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    logic [RC_W-1:0] rc_q, rc_d;
    logic [1:0]      idx_q, idx_d;
    frame_t          pend_q, pend_d;
    frame_t          disp_q, disp_d;
    frame_t          in_w;
    logic            tc;
    logic            wrap;
    logic [15:0]     shifted;
    logic            auto_blank;
    logic            dark;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            fs_q, fs_d;

    // Next-state for the scan position, the double buffer and the output drive
    always_comb begin
        in_w    = '{blank: bus.blank_mask, dp: bus.dp_mask, value: bus.value};
        tc      = (rc_q == RC_LAST);
        rc_d    = tc ? '0 : rc_q + RC_W'(1);
        idx_d   = tc ? idx_q + 2'd1 : idx_q;
        wrap    = tc && (idx_q == 2'd3);
        pend_d  = bus.load ? in_w : pend_q;
        // a load on the wrap edge bypasses pending so it shows in the new frame
        disp_d  = wrap ? (bus.load ? in_w : pend_q) : disp_q;

        shifted = disp_q.value >> {idx_q, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
        auto_blank = (idx_q != 2'd0) && (shifted == 16'h0000);
`else
        auto_blank = 1'b0;
`endif
        dark    = disp_q.blank[idx_q] | auto_blank;
        an_d    = dark ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d   = hex_decode(shifted[3:0]);
        dp_d    = dark | ~disp_q.dp[idx_q];
        fs_d    = (idx_q == 2'd0) && (rc_q == '0);
    end

    // State and registered outputs; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q   <= '0;
            idx_q  <= 2'd0;
            pend_q <= '0;
            disp_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            rc_q   <= rc_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart to the push-button input path. Buttons bring user events in; this block drives a 4-digit multiplexed common-anode seven-segment display out.
- Takes a 16-bit hex value plus decimal-point and blank masks and time-multiplexes the digits with a refresh counter.
- Values are double-buffered so the display never tears mid-frame.
- Sits at top level next to the push-button detector, on the raw board clock.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range 2..2^20.

Ports:
- clk  input  1  board clock
- rst  input  1  synchronous reset, active-high
- value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost)
- dp_mask  input  4  decimal point request per digit; 1 = lit
- blank_mask  input  4  per digit; 1 = digit dark
- load  input  1  one-cycle strobe; captures value/dp_mask/blank_mask into the pending register
- an  output  4  anode enables, active-low, one-hot-low while scanning
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low
- frame_start  output  1  one-cycle pulse when the digit 0 slot begins

Behaviour:
- Refresh counter rc:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Width is clog2(REFRESH_DIV).
  - The terminal count tc is asserted when rc == REFRESH_DIV-1.
- Digit index idx (2 bits):
  - Advances 0→1→2→3→0 on tc.
  - The cycle in which idx becomes 0 is the frame boundary.
- Pending register:
  - Loaded from the inputs whenever load=1.
  - load held high for several cycles re-captures every cycle.
- Display register:
  - Copied from pending at each frame boundary, i.e. the same edge on which idx wraps 3→0.
  - If load=1 on that same edge, the display register takes the input values directly (load bypass), so the new value shows in the starting frame.
- Output registers:
  - an, seg, dp are registered from the display register and idx.
  - They change exactly one clk after idx changes; output latency is 1 cycle.
  - an = ~(1<<idx). If blank_mask[idx]=1, an=4'b1111 for that slot.
  - seg holds the active-low hex decode of nibble idx, 0..F:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - dp = ~dp_mask[idx]; forced to 1 when the digit is blanked.
- frame_start: registered, high for exactly one cycle, aligned with the first cycle an shows digit 0.
- Reset (synchronous, active-high):
  - Clears rc, idx, pending and display registers to 0.
  - Drives an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
  - Applies mid-frame too: state aborts immediately and no partial digit is held.
- First cycle after rst deasserts:
  - Registers update from idx=0 with value 0.
  - an=1110, seg=1000000, dp=1, frame_start=1.
- Scan period is 4*REFRESH_DIV cycles; at the default on 100 MHz that is 250 Hz per frame.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit k in 1..3 is auto-blanked when its nibble and all higher nibbles of the display register are zero. This is OR'd with blank_mask. Digit 0 is never auto-blanked, so value 0 shows "0".
  - Example: value 16'h0042 → digits 3,2 dark; "42" visible.
- Not defined: all digits show their nibble unless blank_mask says otherwise; 16'h0042 shows "0042".
- Either way the decision uses the display register, not pending.

Test Plan:
- REFRESH_DIV=4, reset 3 cycles, release → an=1110, seg=1000000, frame_start=1 on the first cycle. an sequence 1110,1101,1011,0111 each held 4 cycles; frame_start recurs every 16 cycles.
- load with value=16'h12AF mid-frame (idx=1) → current frame still shows 0000. Next frame shows digit0 seg=0001110 (F), digit1 0001000 (A), digit2 0100100 (2), digit3 1111001 (1).
- load with value=16'h0005 on the exact wrap edge idx 3→0 → digit 0 seg=0010010 in that same frame (bypass); frame_start still pulses once.
- dp_mask=4'b0100, blank_mask=4'b1000, load → dp=0 only in the digit 2 slot; digit 3 slot has an=1111, dp=1.
- rst asserted while idx=2 → next cycle an=1111, seg=1111111. After release, the scan restarts at digit 0 with the display register cleared to 0.
- With LEADING_ZERO_BLANK_EN, load 16'h0000 → only digit 0 lit, showing 1000000. Load 16'h0100 → digit 3 dark, digits 2..0 show "100".
